seg7_capture: RTL and testbench

- Receive-side counterpart of the board's binary-to-7-segment display path.
- Samples a 7-segment pin bus (A..G), waits until the pattern is stable, then decodes it back to a 4-bit digit.
- Flags blank and illegal patterns.
- Used as an on-board loopback monitor and as a self-check for display drivers; sits between the segment pins and any checker or logic that consumes the digit.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/seg7_to_binary.sv | 43 ++++
 rtl/seg7_capture.sv | 137 +++++++++++++
 tb/tb_seg7_capture.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment capture path: glyph encodings
// ({G,F,E,D,C,B,A}, active-high) and the capture FSM state type.
package seg7_pkg;

    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [SEG_W-1:0] GLYPH_0     = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1     = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2     = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3     = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4     = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5     = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6     = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7     = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8     = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9     = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A     = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B     = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C     = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D     = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E     = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F     = 7'h71;
    localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'h00;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } cap_state_e;

endpackage

// File: rtl/seg7_to_binary.sv
// Combinational 7-segment glyph decoder. Hex glyphs A..F are accepted
// only when SEG7_CAPTURE_HEX_EN is defined; otherwise they are illegal.
module seg7_to_binary
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        blank = 1'b0;
        case (seg)
            GLYPH_0: digit = 4'd0;
            GLYPH_1: digit = 4'd1;
            GLYPH_2: digit = 4'd2;
            GLYPH_3: digit = 4'd3;
            GLYPH_4: digit = 4'd4;
            GLYPH_5: digit = 4'd5;
            GLYPH_6: digit = 4'd6;
            GLYPH_7: digit = 4'd7;
            GLYPH_8: digit = 4'd8;
            GLYPH_9: digit = 4'd9;
`ifdef SEG7_CAPTURE_HEX_EN
            GLYPH_A: digit = 4'd10;
            GLYPH_B: digit = 4'd11;
            GLYPH_C: digit = 4'd12;
            GLYPH_D: digit = 4'd13;
            GLYPH_E: digit = 4'd14;
            GLYPH_F: digit = 4'd15;
`endif
            GLYPH_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples asynchronous 7-segment pins, waits for a stable pattern and decodes
// it to a digit with blank/illegal flags. Hex glyphs via SEG7_CAPTURE_HEX_EN.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 250000,
    parameter logic        ACTIVE_LOW    = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       S1_A,
    input  logic       S1_B,
    input  logic       S1_C,
    input  logic       S1_D,
    input  logic       S1_E,
    input  logic       S1_F,
    input  logic       S1_G,
    output logic [3:0] o_Digit,
    output logic       o_Valid,
    output logic       o_Blank,
    output logic       o_Error,
    output logic       o_Busy
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
    // Capture fires on the cycle the counter would step to STABLE_CYCLES-1.
    localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [SEG_W-1:0] PINS_OFF = {SEG_W{ACTIVE_LOW}};

    logic [SEG_W-1:0]   pins_raw;
    logic [SEG_W-1:0]   sync1_d, sync1_q;
    logic [SEG_W-1:0]   sync2_d, sync2_q;
    logic [SEG_W-1:0]   seg;
    cap_state_e         state_d, state_q;
    logic [SEG_W-1:0]   held_d, held_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [DIGIT_W-1:0] digit_d, digit_q;
    logic               valid_d, valid_q;
    logic               blank_d, blank_q;
    logic               error_d, error_q;
    logic               busy_d, busy_q;
    logic [DIGIT_W-1:0] dec_digit;
    logic               dec_legal;
    logic               dec_blank;

    assign pins_raw = {S1_G, S1_F, S1_E, S1_D, S1_C, S1_B, S1_A};
    assign seg      = ACTIVE_LOW ? ~sync2_q : sync2_q;

    seg7_to_binary u_dec (
        .seg   (held_q),
        .digit (dec_digit),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    // Next-state: synchronizer shift, settle tracking and registered decode.
    always_comb begin
        sync1_d = pins_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        held_d  = held_q;
        cnt_d   = cnt_q;
        digit_d = digit_q;
        valid_d = 1'b0;
        blank_d = blank_q;
        error_d = error_q;
        busy_d  = busy_q;
        case (state_q)
            STABLE: begin
                if (seg != held_q) begin
                    state_d = SETTLING;
                    held_d  = seg;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SETTLING: begin
                if (seg != held_q) begin
                    held_d = seg;
                    cnt_d  = '0;
                end else if (cnt_q == CAP_CNT) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    if (dec_legal) begin
                        digit_d = dec_digit;
                        valid_d = 1'b1;
                        blank_d = 1'b0;
                        error_d = 1'b0;
                    end else if (dec_blank) begin
                        blank_d = 1'b1;
                        error_d = 1'b0;
                    end else begin
                        blank_d = 1'b0;
                        error_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= PINS_OFF;
            sync2_q <= PINS_OFF;
            state_q <= STABLE;
            held_q  <= GLYPH_BLANK;
            cnt_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            blank_q <= 1'b1;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    assign o_Digit = digit_q;
    assign o_Valid = valid_q;
    assign o_Blank = blank_q;
    assign o_Error = error_q;
    assign o_Busy  = busy_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture (STABLE_CYCLES=4, active-low pins).
// Each capture (falling o_Busy) is matched against a queued expectation.
module tb_seg7_capture;

    localparam logic [6:0] G3  = 7'h4F;
    localparam logic [6:0] G5  = 7'h6D;
    localparam logic [6:0] G7  = 7'h07;
    localparam logic [6:0] G8  = 7'h7F;
    localparam logic [6:0] GB  = 7'h7C;
    localparam logic [6:0] ILL = 7'h41;

    typedef struct {
        int         cyc;
        logic       v;
        logic [3:0] d;
        logic       b;
        logic       e;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [6:0] pins = 7'h7F;
    logic [3:0] o_Digit;
    logic       o_Valid, o_Blank, o_Error, o_Busy;
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    exp_t       exp_q[$];
    logic       prev_busy = 1'b0;

    seg7_capture #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .S1_A    (pins[0]),
        .S1_B    (pins[1]),
        .S1_C    (pins[2]),
        .S1_D    (pins[3]),
        .S1_E    (pins[4]),
        .S1_F    (pins[5]),
        .S1_G    (pins[6]),
        .o_Digit (o_Digit),
        .o_Valid (o_Valid),
        .o_Blank (o_Blank),
        .o_Error (o_Error),
        .o_Busy  (o_Busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every capture ends a busy period; o_Valid must never appear elsewhere.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && !o_Busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_capture", 32'(o_Digit), 32'd99);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("capture_cycle", 32'(cyc), 32'(e.cyc));
                    check("capture_valid", 32'(o_Valid), 32'(e.v));
                    check("capture_digit", 32'(o_Digit), 32'(e.d));
                    check("capture_blank", 32'(o_Blank), 32'(e.b));
                    check("capture_error", 32'(o_Error), 32'(e.e));
                end
            end else if (o_Valid) begin
                check("spurious_valid", 32'(o_Valid), 32'd0);
            end
            prev_busy = o_Busy;
        end
    end

    // Drive a pattern, expect one capture six cycles after the pin change.
    task automatic apply(input logic [6:0] g, input logic v, input logic [3:0] d,
                         input logic b, input logic e);
        exp_t x;
        @(posedge CLK);
        #1;
        pins = ~g;
        x.cyc = cyc + 6; x.v = v; x.d = d; x.b = b; x.e = e;
        exp_q.push_back(x);
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("busy_settling", 32'(o_Busy), 32'd1);
        repeat (8) @(posedge CLK);
    endtask

    initial begin
        exp_t x;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_digit", 32'(o_Digit), 32'd0);
        check("rst_valid", 32'(o_Valid), 32'd0);
        check("rst_blank", 32'(o_Blank), 32'd1);
        check("rst_error", 32'(o_Error), 32'd0);
        check("rst_busy",  32'(o_Busy),  32'd0);
        RST_N = 1'b1;

        // All segments off never produces a capture.
        repeat (20) @(posedge CLK);
        @(negedge CLK);
        check("blank_busy",  32'(o_Busy),  32'd0);
        check("blank_blank", 32'(o_Blank), 32'd1);
        check("blank_digit", 32'(o_Digit), 32'd0);

        apply(G3, 1'b1, 4'd3, 1'b0, 1'b0);

        // Glyph 7 with segment A toggling every 2 cycles, then held.
        @(posedge CLK);
        #1;
        pins = ~G7;
        repeat (10) begin
            repeat (2) @(posedge CLK);
            #1;
            pins[0] = ~pins[0];
        end
        x.cyc = cyc + 6; x.v = 1'b1; x.d = 4'd7; x.b = 1'b0; x.e = 1'b0;
        exp_q.push_back(x);
        repeat (12) @(posedge CLK);

        apply(ILL, 1'b0, 4'd7, 1'b0, 1'b1);
        apply(G8,  1'b1, 4'd8, 1'b0, 1'b0);
`ifdef SEG7_CAPTURE_HEX_EN
        apply(GB,  1'b1, 4'd11, 1'b0, 1'b0);
`else
        apply(GB,  1'b0, 4'd8,  1'b0, 1'b1);
`endif

        // Reset two cycles into settling on glyph 5 discards the capture.
        @(posedge CLK);
        #1;
        pins = ~G5;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        check("g5_busy", 32'(o_Busy), 32'd1);
        #1;
        RST_N = 1'b0;
        #1;
        check("mid_rst_digit", 32'(o_Digit), 32'd0);
        check("mid_rst_valid", 32'(o_Valid), 32'd0);
        check("mid_rst_blank", 32'(o_Blank), 32'd1);
        check("mid_rst_error", 32'(o_Error), 32'd0);
        check("mid_rst_busy",  32'(o_Busy),  32'd0);
        pins = 7'h7F;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(posedge CLK);
        @(negedge CLK);
        check("post_rst_blank", 32'(o_Blank), 32'd1);
        check("post_rst_digit", 32'(o_Digit), 32'd0);
        check("pending_captures", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
